// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts synchronized rising edges of sig_in over a fixed
// clk-timed gate window and publishes the count with a one-cycle valid pulse.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GATE  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic             sync1_q, sync2_q, dly_q;
  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             rise;

  assign rise = sync2_q & ~dly_q;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      GATE: begin
        // abort takes priority over window completion
        if (!en) state_d = IDLE;
        else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          if (rise) begin
            if (edge_cnt_q == MAX) sat_d = 1'b1;
            else edge_cnt_d = edge_cnt_q + 1'b1;
          end
          if (gate_cnt_q == LAST) state_d = LATCH;
        end
      end
      LATCH: begin
        freq_d     = edge_cnt_q;
        ovf_d      = sat_q;
        valid_d    = 1'b1;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        gate_cnt_d = '0;
        state_d    = en ? GATE : IDLE;
      end
      default: begin
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        gate_cnt_d = '0;
        state_d    = en ? GATE : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= sig_in;
      sync2_q    <= sync1_q;
      dly_q      <= sync2_q;
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  // valid is registered so it coincides with the new freq_out/overflow
  assign freq_out = freq_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  assign busy     = (state_q == GATE);
endmodule
